// File: rtl/ram_arbiter_if.sv
// Bus bundle between the fetch / load-store requesters, the arbiter and the
// single-port data RAM. The arbiter takes the slave view; the requester and
// RAM side (the environment around the arbiter) take the master view.
interface ram_arbiter_if;
    // instruction-fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    // load/store port
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_err;
    // RAM side
    logic        ram_clr;
    logic [31:0] ram_address;
    logic        ram_write;
    logic        ram_read;
    logic [31:0] ram_datain;
    logic [31:0] ram_dataout;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata, if_err,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output ram_clr, ram_address, ram_write, ram_read, ram_datain,
        input  ram_dataout
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  ram_clr, ram_address, ram_write, ram_read, ram_datain,
        output ram_dataout
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port word RAM between the
// fetch port (read-only) and the load/store port. Byte addresses are checked
// and converted to word indices; bad accesses never reach the RAM and are
// answered with an error pulse one cycle after their grant.
module ram_arbiter #(
    parameter int ADDR_W = 10
) (
    input  logic         clk,
    input  logic         clr_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    state_t state_reg;
    logic   last_reg;        // port granted most recently
    logic   resp_valid_reg;  // a response is due this cycle
    logic   resp_port_reg;   // which port it belongs to
    logic   resp_err_reg;    // response is an error
    logic   resp_we_reg;     // error response belongs to a store (no rvalid)

    logic        run;
    logic        gnt_if;
    logic        gnt_d;
    logic        any_gnt;
    logic [31:0] sel_addr;
    logic        bad;
    logic        is_read;
    logic [ADDR_W-1:0] word_idx;

    // Arbitration, address check and RAM strobes for the current cycle
    always_comb begin
        run      = clr_n && (state_reg == RUN);
        // on contention the port that was not served last wins
        gnt_if   = run && bus.if_req && (!bus.d_req || last_reg == PORT_D);
        gnt_d    = run && bus.d_req  && (!bus.if_req || last_reg == PORT_IF);
        any_gnt  = gnt_if || gnt_d;
        sel_addr = gnt_d ? bus.d_addr : bus.if_addr;
        bad      = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
        is_read  = gnt_if || (gnt_d && !bus.d_we);
        word_idx = sel_addr[ADDR_W+1:2];

        bus.if_gnt      = gnt_if;
        bus.d_gnt       = gnt_d;
        bus.ram_clr     = !clr_n || (state_reg == INIT);
        bus.ram_read    = any_gnt && !bad && is_read;
        bus.ram_write   = gnt_d && bus.d_we && !bad;
        bus.ram_address = (any_gnt && !bad) ? {{(32-ADDR_W){1'b0}}, word_idx} : 32'd0;
        bus.ram_datain  = bus.ram_write ? bus.d_wdata : 32'd0;
    end

    // Response outputs from the tracker; reset masks anything still in flight
    always_comb begin
        bus.if_rvalid = clr_n && resp_valid_reg && (resp_port_reg == PORT_IF);
        bus.if_err    = bus.if_rvalid && resp_err_reg;
        bus.if_rdata  = (bus.if_rvalid && !resp_err_reg) ? bus.ram_dataout : 32'd0;

        bus.d_err     = clr_n && resp_valid_reg && (resp_port_reg == PORT_D) && resp_err_reg;
        bus.d_rvalid  = clr_n && resp_valid_reg && (resp_port_reg == PORT_D) && !resp_we_reg;
        bus.d_rdata   = (bus.d_rvalid && !resp_err_reg) ? bus.ram_dataout : 32'd0;
    end

    // Sequencer state, round-robin pointer and response tracker
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_reg      <= INIT;
            last_reg       <= PORT_D;
            resp_valid_reg <= 1'b0;
            resp_port_reg  <= PORT_IF;
            resp_err_reg   <= 1'b0;
            resp_we_reg    <= 1'b0;
        end else begin
            state_reg <= RUN;
            if (any_gnt) begin
                last_reg <= gnt_d ? PORT_D : PORT_IF;
            end
            if (any_gnt && (is_read || bad)) begin
                resp_valid_reg <= 1'b1;
                resp_port_reg  <= gnt_d ? PORT_D : PORT_IF;
                resp_err_reg   <= bad;
                resp_we_reg    <= gnt_d && bus.d_we;
            end else begin
                resp_valid_reg <= 1'b0;
                resp_port_reg  <= PORT_IF;
                resp_err_reg   <= 1'b0;
                resp_we_reg    <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 1024x32 RAM model.
module tb_ram_arbiter;
    logic clk;
    logic clr_n;
    int   n_tests;
    int   n_fail;

    ram_arbiter_if bus ();

    ram_arbiter #(.ADDR_W(10)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: clear strobe, write, registered read
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.ram_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else if (bus.ram_write) begin
            mem[bus.ram_address[9:0]] <= bus.ram_datain;
        end
        if (bus.ram_read) bus.ram_dataout <= mem[bus.ram_address[9:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prev_if;
        n_tests = 0;
        n_fail  = 0;
        clr_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 32'd0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
        tick();

        // reset held 3 cycles with a fetch pending
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("rst%0d_if_gnt", i), 32'(bus.if_gnt), 0);
            chk($sformatf("rst%0d_ram_clr", i), 32'(bus.ram_clr), 1);
            chk($sformatf("rst%0d_ram_read", i), 32'(bus.ram_read), 0);
            tick();
        end

        // INIT cycle: still clearing, no grant
        clr_n = 1'b1;
        #2;
        chk("init_ram_clr", 32'(bus.ram_clr), 1);
        chk("init_if_gnt", 32'(bus.if_gnt), 0);
        tick();
        #2;
        chk("first_if_gnt", 32'(bus.if_gnt), 1);
        chk("first_ram_read", 32'(bus.ram_read), 1);
        chk("first_ram_clr", 32'(bus.ram_clr), 0);
        tick();
        bus.if_req = 1'b0;

        // store 0xDEADBEEF to 0x10 (word 4); first fetch returns cleared data
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h10; bus.d_wdata = 32'hDEADBEEF;
        #2;
        chk("first_if_rvalid", 32'(bus.if_rvalid), 1);
        chk("first_if_rdata", bus.if_rdata, 32'd0);
        chk("st_d_gnt", 32'(bus.d_gnt), 1);
        chk("st_ram_write", 32'(bus.ram_write), 1);
        chk("st_ram_address", bus.ram_address, 32'd4);
        chk("st_ram_datain", bus.ram_datain, 32'hDEADBEEF);
        tick();
        bus.d_we = 1'b0;
        #2;
        chk("ld_d_gnt", 32'(bus.d_gnt), 1);
        chk("ld_ram_read", 32'(bus.ram_read), 1);
        chk("ld_ram_datain", bus.ram_datain, 32'd0);
        chk("st_no_rvalid", 32'(bus.d_rvalid), 0);
        tick();
        bus.d_req = 1'b0;
        #2;
        chk("ld_d_rvalid", 32'(bus.d_rvalid), 1);
        chk("ld_d_rdata", bus.d_rdata, 32'hDEADBEEF);
        tick();

        // preload words 0,1,2 with 1,2,3 through the store port
        for (int i = 0; i < 3; i++) begin
            bus.d_req = 1'b1; bus.d_we = 1'b1;
            bus.d_addr = 32'(4 * i); bus.d_wdata = 32'(i + 1);
            tick();
        end
        bus.d_req = 1'b0; bus.d_we = 1'b0;

        // contention: fetch 0x0 (=1) vs load 0x4 (=2); last grant was D so IF leads
        prev_if = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.if_req = (i < 6); bus.if_addr = 32'h0;
            bus.d_req  = (i < 6); bus.d_addr  = 32'h4;
            #2;
            if (i < 6) begin
                chk($sformatf("cont%0d_if_gnt", i), 32'(bus.if_gnt), 32'((i % 2) == 0));
                chk($sformatf("cont%0d_d_gnt", i), 32'(bus.d_gnt), 32'((i % 2) == 1));
            end
            if (i > 0) begin
                chk($sformatf("cont%0d_if_rvalid", i), 32'(bus.if_rvalid), 32'(prev_if));
                chk($sformatf("cont%0d_d_rvalid", i), 32'(bus.d_rvalid), 32'(!prev_if));
                if (prev_if) chk($sformatf("cont%0d_if_rdata", i), bus.if_rdata, 32'd1);
                else         chk($sformatf("cont%0d_d_rdata", i), bus.d_rdata, 32'd2);
            end
            prev_if = ((i % 2) == 0);
            tick();
        end

        // back-to-back fetches 0x0, 0x4, 0x8
        for (int i = 0; i < 4; i++) begin
            bus.if_req = (i < 3); bus.if_addr = 32'(4 * i);
            #2;
            if (i < 3) chk($sformatf("bb%0d_if_gnt", i), 32'(bus.if_gnt), 1);
            if (i > 0) begin
                chk($sformatf("bb%0d_if_rvalid", i), 32'(bus.if_rvalid), 1);
                chk($sformatf("bb%0d_if_rdata", i), bus.if_rdata, 32'(i));
            end
            tick();
        end

        // misaligned fetch
        bus.if_req = 1'b1; bus.if_addr = 32'h2;
        #2;
        chk("misal_if_gnt", 32'(bus.if_gnt), 1);
        chk("misal_ram_read", 32'(bus.ram_read), 0);
        chk("misal_ram_address", bus.ram_address, 32'd0);
        tick();
        // out-of-range store, granted while the fetch error returns
        bus.if_req = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1000; bus.d_wdata = 32'h5;
        #2;
        chk("misal_if_rvalid", 32'(bus.if_rvalid), 1);
        chk("misal_if_err", 32'(bus.if_err), 1);
        chk("misal_if_rdata", bus.if_rdata, 32'd0);
        chk("oor_d_gnt", 32'(bus.d_gnt), 1);
        chk("oor_ram_write", 32'(bus.ram_write), 0);
        chk("oor_ram_datain", bus.ram_datain, 32'd0);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        #2;
        chk("oor_d_err", 32'(bus.d_err), 1);
        chk("oor_d_rvalid", 32'(bus.d_rvalid), 0);
        chk("oor_if_err", 32'(bus.if_err), 0);
        tick();

        // reset in the cycle after a load grant drops the response
        bus.d_req = 1'b1; bus.d_addr = 32'h10;
        #2;
        chk("mid_d_gnt", 32'(bus.d_gnt), 1);
        tick();
        bus.d_req = 1'b0; clr_n = 1'b0;
        #2;
        chk("mid_d_rvalid", 32'(bus.d_rvalid), 0);
        chk("mid_d_rdata", bus.d_rdata, 32'd0);
        chk("mid_d_err", 32'(bus.d_err), 0);
        chk("mid_ram_clr", 32'(bus.ram_clr), 1);
        tick();
        #2;
        chk("mid2_d_rvalid", 32'(bus.d_rvalid), 0);
        clr_n = 1'b1;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
